// File: rtl/fact_accel.sv
// Memory-mapped factorial accelerator: the core writes n and GO, polls STATUS and reads n! from RESULT.
// The product is built iteratively with one multiply per clock.
module fact_accel #(
    parameter int DATA_W = 32,
    parameter int N_W    = 4,
    parameter int N_MAX  = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [1:0]        a,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] rd,
    output logic              done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_MULT  = 2'd2;

    localparam logic [1:0] OFF_N      = 2'd0;
    localparam logic [1:0] OFF_GO     = 2'd1;
    localparam logic [1:0] OFF_STATUS = 2'd2;
    localparam logic [1:0] OFF_RESULT = 2'd3;

    localparam logic [N_W-1:0]    N_LIMIT  = N_W'(N_MAX);
    localparam logic [N_W-1:0]    CNT_ONE  = N_W'(1);
    localparam logic [DATA_W-1:0] PROD_ONE = DATA_W'(1);

    logic [1:0]        state_q,  state_d;
    logic [N_W-1:0]    n_q,      n_d;
    logic [N_W-1:0]    cnt_q,    cnt_d;
    logic [DATA_W-1:0] prod_q,   prod_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              done_q,   done_d;
    logic              err_q,    err_d;

    logic busy;
    logic wr_n;
    logic go;
    logic wd_unused;

    assign busy = (state_q != ST_IDLE);

    // Writes to N and GO are honoured only while idle; STATUS and RESULT are read-only.
    assign wr_n = we && (a == OFF_N)  && !busy;
    assign go   = we && (a == OFF_GO) && wd[0] && !busy;

    assign wd_unused = ^wd[DATA_W-1:N_W];

    // NOTE: every next-state signal takes its current value first, so no path through this block can infer a latch.
    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        result_d = result_q;
        done_d   = done_q;
        err_d    = err_q;

        case (state_q)
            ST_IDLE: begin
                if (wr_n) begin
                    n_d = wd[N_W-1:0];
                end
                if (go) begin
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    state_d = ST_CHECK;
                end
            end

            ST_CHECK: begin
                if (n_q > N_LIMIT) begin
                    err_d    = 1'b1;
                    done_d   = 1'b1;
                    result_d = '0;
                    state_d  = ST_IDLE;
                end else begin
                    prod_d  = PROD_ONE;
                    cnt_d   = n_q;
                    state_d = ST_MULT;
                end
            end

            ST_MULT: begin
                // cnt stops at 1 (or stays at 0 for n=0); the product is already final there.
                if (cnt_q <= CNT_ONE) begin
                    result_d = prod_q;
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    prod_d = prod_q * DATA_W'(cnt_q);
                    cnt_d  = cnt_q - CNT_ONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            n_q      <= '0;
            cnt_q    <= '0;
            prod_q   <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
            result_q <= result_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        rd = '0;
        case (a)
            OFF_N:      rd = DATA_W'(n_q);
            OFF_GO:     rd = '0;
            OFF_STATUS: rd = {{(DATA_W-3){1'b0}}, busy, err_q, done_q};
            OFF_RESULT: rd = result_q;
            default:    rd = '0;
        endcase
    end

    assign done = done_q;

endmodule

// File: tb/tb_fact_accel.sv
// Randomised and directed bench for fact_accel against a plain-arithmetic factorial model.
module tb_fact_accel;

    localparam int DATA_W = 32;

    logic              clk;
    logic              reset;
    logic              we;
    logic [1:0]        a;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] rd;
    logic              done;

    int n_checks;
    int n_fail;

    fact_accel #(.DATA_W(32), .N_W(4), .N_MAX(12)) dut (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .a     (a),
        .wd    (wd),
        .rd    (rd),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: n! truncated to 32 bits, or 0 when n exceeds the supported range.
    function automatic logic [31:0] ref_result(input int n);
        longint p = 1;
        if (n > 12) return 32'd0;
        for (int i = 2; i <= n; i++) p = p * i;
        return p[31:0];
    endfunction

    function automatic int ref_latency(input int n);
        if (n > 12) return 1;
        return ((n < 1) ? 1 : n) + 1;
    endfunction

    task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
        @(negedge clk);
        we = 1'b1;
        a  = addr;
        wd = data;
        @(posedge clk);
        #1;
        we = 1'b0;
        wd = '0;
    endtask

    task automatic bus_read(input logic [1:0] addr, output logic [31:0] v);
        a = addr;
        #1;
        v = rd;
    endtask

    // Runs one computation from the GO edge and checks status every edge and the final result.
    task automatic run_fact(input int n, input string tag);
        logic [31:0] v;
        int lat;
        lat = ref_latency(n);
        bus_write(2'd0, 32'(n));
        bus_write(2'd1, 32'd1);
        for (int e = 1; e < lat; e++) begin
            @(posedge clk);
            #1;
        end
        bus_read(2'd2, v);
        n_checks++;
        if (v !== 32'h4 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s n=%0d pre-final status: got 0x%0h done=%0b, want 0x4 done=0", tag, n, v, done);
        end
        @(posedge clk);
        #1;
        bus_read(2'd2, v);
        n_checks++;
        if (v !== ((n > 12) ? 32'h3 : 32'h1) || done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s n=%0d final status: got 0x%0h done=%0b, want 0x%0h done=1",
                     tag, n, v, done, (n > 12) ? 3 : 1);
        end
        bus_read(2'd3, v);
        n_checks++;
        if (v !== ref_result(n)) begin
            n_fail++;
            $display("FAIL %s n=%0d result: got 0x%0h, want 0x%0h", tag, n, v, ref_result(n));
        end
    endtask

    task automatic test_reset();
        logic [31:0] v;
        reset = 1'b0;
        we    = 1'b0;
        a     = 2'd0;
        wd    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            bus_read(2'(k), v);
            n_checks++;
            if (v !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_reg a=%0d: got 0x%0h, want 0x0", k, v);
            end
        end
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_done: got %0b, want 0", done);
        end
    endtask

    task automatic test_directed();
        int vec[6] = '{5, 0, 1, 12, 13, 15};
        foreach (vec[i]) run_fact(vec[i], "directed");
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++) run_fact(int'($urandom_range(0, 15)), "random");
    endtask

    task automatic test_ignored_writes();
        logic [31:0] v;
        logic [31:0] want;
        run_fact(7, "pre_ignore");
        want = ref_result(7);
        bus_write(2'd3, 32'hDEAD_BEEF);
        bus_write(2'd2, 32'hFFFF_FFFF);
        bus_write(2'd1, 32'hFFFF_FFFE);
        @(posedge clk);
        #1;
        bus_read(2'd2, v);
        n_checks++;
        if (v !== 32'h1) begin
            n_fail++;
            $display("FAIL ignore_status: got 0x%0h, want 0x1", v);
        end
        bus_read(2'd3, v);
        n_checks++;
        if (v !== want) begin
            n_fail++;
            $display("FAIL ignore_result: got 0x%0h, want 0x%0h", v, want);
        end
        bus_read(2'd1, v);
        n_checks++;
        if (v !== 32'd0) begin
            n_fail++;
            $display("FAIL go_reads_zero: got 0x%0h, want 0x0", v);
        end
    endtask

    task automatic test_busy_lockout();
        logic [31:0] v;
        bus_write(2'd0, 32'd6);
        bus_write(2'd1, 32'd1);
        bus_write(2'd0, 32'd3);
        bus_write(2'd1, 32'd1);
        repeat (ref_latency(6) - 2) begin
            @(posedge clk);
            #1;
        end
        bus_read(2'd2, v);
        n_checks++;
        if (v !== 32'h1) begin
            n_fail++;
            $display("FAIL lockout_status: got 0x%0h, want 0x1", v);
        end
        bus_read(2'd3, v);
        n_checks++;
        if (v !== ref_result(6)) begin
            n_fail++;
            $display("FAIL lockout_result: got 0x%0h, want 0x%0h", v, ref_result(6));
        end
        bus_read(2'd0, v);
        n_checks++;
        if (v !== 32'd6) begin
            n_fail++;
            $display("FAIL lockout_n: got 0x%0h, want 0x6", v);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] v;
        bus_write(2'd0, 32'd10);
        bus_write(2'd1, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        bus_read(2'd2, v);
        n_checks++;
        if (v !== 32'h4) begin
            n_fail++;
            $display("FAIL midop_busy: got 0x%0h, want 0x4", v);
        end
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL async_done: got %0b, want 0", done);
        end
        bus_read(2'd3, v);
        n_checks++;
        if (v !== 32'd0) begin
            n_fail++;
            $display("FAIL async_result: got 0x%0h, want 0x0", v);
        end
        bus_read(2'd2, v);
        n_checks++;
        if (v !== 32'd0) begin
            n_fail++;
            $display("FAIL async_status: got 0x%0h, want 0x0", v);
        end
        @(negedge clk);
        reset = 1'b1;
        run_fact(4, "after_reset");
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_directed();
        test_random();
        test_ignored_writes();
        test_busy_lockout();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
